// File: rtl/fifo_traffic_checker.sv
// Traffic generator/checker for a single-clock FIFO: fill-then-drain or concurrent streaming
// of a decrementing data pattern. Define FIFO_CHK_WATER_LEVEL_EN to add water-level checks.
module fifo_traffic_checker #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 15,
  parameter int RD_LATENCY  = 1,
  parameter int STREAM_LEN  = 1024
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_full,
  input  logic [DEPTH_WIDTH:0]  wr_water_level,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_cnt,
  output logic [2:0]            dbg_state
);

  // Handshake: wr_en/rd_en are combinational from state and the same-cycle flags; a word moves
  // on each rising edge where its enable is 1, and an enable is never raised while its flag is 1.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] STREAM = 3'd4;
  localparam logic [2:0] FLUSH  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam int CW = DEPTH_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C    = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [CW-1:0] DEPTH_M1   = DEPTH_C - CW'(1);
  localparam logic [CW-1:0] LEN_C      = CW'(STREAM_LEN);
  localparam logic [2:0]    GAP_LAST   = 3'd3;
  localparam logic [2:0]    FLUSH_LAST = 3'(RD_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic [2:0]            state_q, state_d;
  logic [2:0]            tmr_q, tmr_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0] wr_pat_q, exp_q;
  logic                  tog_q;
  logic [2:0]            err_q, err_d;
  logic [RD_LATENCY-1:0] pipe_v_q;
  logic [DATA_WIDTH-1:0] pipe_d_q [RD_LATENCY];
  logic                  launch, data_err;
  logic [1:0]            flag_err;
  logic [3:0]            err_sum;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    flag_err = 2'd0;
    launch   = start && (state_q == IDLE || state_q == DONE);
    case (state_q)
      IDLE, DONE: if (launch) state_d = mode ? STREAM : FILL;
      FILL: begin
        wr_en = !wr_full && (wr_cnt_q < DEPTH_C);
        if (wr_en && wr_cnt_q == DEPTH_M1) begin
          state_d = GAP;
          tmr_d   = 3'd0;
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          if (!wr_full) flag_err = flag_err + 2'd1;
`ifdef FIFO_CHK_WATER_LEVEL_EN
          if (wr_water_level != DEPTH_C) flag_err = flag_err + 2'd1;
`endif
          state_d = DRAIN;
        end else begin
          tmr_d = tmr_q + 3'd1;
        end
      end
      DRAIN: begin
        rd_en = !rd_empty && (rd_cnt_q < DEPTH_C);
        if (rd_en && rd_cnt_q == DEPTH_M1) begin
          state_d = FLUSH;
          tmr_d   = 3'd0;
        end
      end
      STREAM: begin
        wr_en = !wr_full && (wr_cnt_q < LEN_C);
        // Reads are throttled to every other cycle so the FIFO level actually moves.
        rd_en = !rd_empty && tog_q && (rd_cnt_q < LEN_C);
      end
      FLUSH: begin
        if (tmr_q == FLUSH_LAST) begin
          if (!rd_empty) flag_err = flag_err + 2'd1;
`ifdef FIFO_CHK_WATER_LEVEL_EN
          if (wr_water_level != '0) flag_err = flag_err + 2'd1;
`endif
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_cnt_d = wr_en ? wr_cnt_q + CW'(1) : wr_cnt_q;
    rd_cnt_d = rd_en ? rd_cnt_q + CW'(1) : rd_cnt_q;
    if (state_q == STREAM && wr_cnt_d == LEN_C && rd_cnt_d == LEN_C) begin
      state_d = FLUSH;
      tmr_d   = 3'd0;
    end
    if (launch) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end
  end

`ifndef FIFO_CHK_WATER_LEVEL_EN
  logic unused_level;
  assign unused_level = ^wr_water_level;
`endif

  assign data_err = pipe_v_q[RD_LATENCY-1] && (rd_data != pipe_d_q[RD_LATENCY-1]);
  assign err_sum  = {1'b0, err_q} + {3'b000, data_err} + {2'b00, flag_err};
  assign err_d    = launch ? 3'd0 : ((err_sum > 4'd7) ? 3'd7 : err_sum[2:0]);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q  <= IDLE;
      tmr_q    <= 3'd0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_pat_q <= ONES;
      exp_q    <= ONES;
      tog_q    <= 1'b0;
      err_q    <= 3'd0;
      pipe_v_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      tog_q    <= !tog_q;
      err_q    <= err_d;
      if (launch) begin
        wr_pat_q <= ONES;
        exp_q    <= ONES;
      end else begin
        if (wr_en) wr_pat_q <= wr_pat_q - DATA_WIDTH'(1);
        if (rd_en) exp_q <= exp_q - DATA_WIDTH'(1);
      end
      // Stage 0 pairs each issued read with the word it should return.
      pipe_v_q[0] <= rd_en;
      pipe_d_q[0] <= exp_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_d_q[i] <= pipe_d_q[i-1];
      end
    end
  end

  assign wr_data   = wr_pat_q;
  assign busy      = (state_q == FILL) || (state_q == GAP) || (state_q == DRAIN) ||
                     (state_q == STREAM) || (state_q == FLUSH);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == 3'd0);
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_traffic_checker.sv
// Bench for fifo_traffic_checker: a queue-based ideal FIFO with fault knobs, one task per scenario.
module tb_fifo_traffic_checker;

  localparam int DW   = 16;
  localparam int DEPW = 9;
  localparam int RDL  = 1;
  localparam int SLEN = 100;
  localparam int DEPTH = 1 << DEPW;

  logic          clk = 1'b0;
  logic          tb_rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          wr_en, rd_en, wr_full, rd_empty, busy, done, pass;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data_m = '0;
  logic [DEPW:0] wr_water_level;
  logic [2:0]    err_cnt, dbg_state;

  fifo_traffic_checker #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(DEPW), .RD_LATENCY(RDL), .STREAM_LEN(SLEN)
  ) dut (
    .clk(clk), .tb_rst(tb_rst), .start(start), .mode(mode),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_water_level(wr_water_level),
    .rd_en(rd_en), .rd_data(rd_data_m), .rd_empty(rd_empty),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- FIFO model and fault knobs ----------------
  logic [DW-1:0] mq[$];
  int            fifo_cnt = 0;
  int            fifo_cap = DEPTH;
  logic          force_full = 1'b0, force_empty = 1'b0;
  logic          ghost_en = 1'b0, ghost_on = 1'b0, stuck_level = 1'b0, corrupt_all = 1'b0;
  int            corrupt_idx = -1;
  int            wr_idx = 0, rd_idx = 0, bad_wr_data = 0;
  logic [DW-1:0] first_wr = '0, last_wr = '0;
  logic          s_wr, s_rd, s_start, s_rst;
  logic [DW-1:0] s_wd, pop_d;

  assign wr_full        = (fifo_cnt >= fifo_cap) || force_full;
  assign rd_empty       = ((fifo_cnt == 0) || force_empty) && !ghost_on;
  assign wr_water_level = stuck_level ? 10'd511 : 10'(fifo_cnt);

  always @(posedge clk) begin
    s_wr = wr_en; s_rd = rd_en; s_wd = wr_data; s_start = start; s_rst = tb_rst;
    #1;
    if (s_rst) begin
      mq.delete();
      ghost_on = 1'b0;
    end else begin
      if (s_start) begin wr_idx = 0; rd_idx = 0; ghost_on = 1'b0; end
      if (s_wr) begin
        if (s_wd !== 16'(65535 - wr_idx)) bad_wr_data++;
        if (wr_idx == 0) first_wr = s_wd;
        last_wr = s_wd;
        wr_idx++;
        mq.push_back(s_wd);
      end
      if (s_rd && mq.size() > 0) begin
        pop_d = mq.pop_front();
        if (corrupt_all || rd_idx == corrupt_idx) pop_d[0] = ~pop_d[0];
        rd_data_m = pop_d;
        rd_idx++;
        if (ghost_en && rd_idx == DEPTH) ghost_on = 1'b1;
      end
    end
    fifo_cnt = mq.size();
  end

  // Protocol monitor: enables must never coincide with the blocking flag.
  int wr_while_full = 0, rd_while_empty = 0;
  always @(negedge clk) begin
    if (wr_en && wr_full) wr_while_full++;
    if (rd_en && rd_empty) rd_while_empty++;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0, n_bad = 0;

  // ---------------- driver tasks ----------------
  task automatic run_to_done(input logic m, input bit stall);
    int cyc;
    @(negedge clk); mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 6000) begin
      if (stall) begin
        force_full  = ($urandom_range(0, 3) == 0);
        force_empty = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk); cyc++;
    end
    force_full = 1'b0; force_empty = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL run_timeout: done=%b required 1 after %0d cycles", done, cyc); end
  endtask

  function automatic int sat7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tb_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({wr_en, rd_en, busy, done, pass} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: wr_en/rd_en/busy/done/pass=%b required 00000", {wr_en, rd_en, busy, done, pass}); end
    n_cmp++; if (wr_data !== 16'hFFFF) begin n_bad++; $display("FAIL reset_wr_data: got %h required ffff", wr_data); end
    n_cmp++; if (err_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_err: got %0d required 0", err_cnt); end
    tb_rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({busy, done, wr_en} !== 3'b0) begin n_bad++;
      $display("FAIL idle_hold: busy/done/wr_en=%b required 000", {busy, done, wr_en}); end
  endtask

  task automatic test_fill_drain();
    int wf0, re0, bw0;
    wf0 = wr_while_full; re0 = rd_while_empty; bw0 = bad_wr_data;
    run_to_done(1'b0, 1'b1);
    n_cmp++; if (wr_idx != DEPTH || rd_idx != DEPTH) begin n_bad++;
      $display("FAIL fd_counts: writes=%0d reads=%0d required %0d", wr_idx, rd_idx, DEPTH); end
    n_cmp++; if (first_wr !== 16'hFFFF || last_wr !== 16'hFE00) begin n_bad++;
      $display("FAIL fd_pattern_ends: first=%h last=%h required ffff fe00", first_wr, last_wr); end
    n_cmp++; if (bad_wr_data != bw0) begin n_bad++;
      $display("FAIL fd_pattern: %0d bad write words required 0", bad_wr_data - bw0); end
    n_cmp++; if (wr_while_full != wf0 || rd_while_empty != re0) begin n_bad++;
      $display("FAIL fd_protocol: wr_while_full=%0d rd_while_empty=%0d required 0 0",
               wr_while_full - wf0, rd_while_empty - re0); end
    n_cmp++; if ({done, pass, busy} !== 3'b110 || err_cnt !== 3'd0) begin n_bad++;
      $display("FAIL fd_result: done/pass/busy=%b err=%0d required 110 err=0", {done, pass, busy}, err_cnt); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fd_done_hold: done=%b required 1", done); end
  endtask

  task automatic test_corrupt_one();
    corrupt_idx = 3;
    run_to_done(1'b0, 1'b1);
    corrupt_idx = -1;
    n_cmp++; if (err_cnt !== 3'(sat7(1)) || pass !== 1'b0) begin n_bad++;
      $display("FAIL corrupt_one: err=%0d pass=%b required err=1 pass=0", err_cnt, pass); end
  endtask

  task automatic test_corrupt_all();
    corrupt_all = 1'b1;
    run_to_done(1'b0, 1'b0);
    corrupt_all = 1'b0;
    n_cmp++; if (err_cnt !== 3'(sat7(DEPTH)) || pass !== 1'b0) begin n_bad++;
      $display("FAIL corrupt_all: err=%0d pass=%b required err=7 pass=0", err_cnt, pass); end
    repeat (10) @(negedge clk);
    n_cmp++; if (err_cnt !== 3'd7 || done !== 1'b1) begin n_bad++;
      $display("FAIL corrupt_all_hold: err=%0d done=%b required 7 1", err_cnt, done); end
  endtask

  task automatic test_flag_errors();
    int exp_err;
    fifo_cap = 2 * DEPTH;           // full flag never rises at the end of the fill
    run_to_done(1'b0, 1'b1);
    fifo_cap = DEPTH;
    n_cmp++; if (err_cnt !== 3'd1 || pass !== 1'b0) begin n_bad++;
      $display("FAIL flag_full_missing: err=%0d pass=%b required 1 0", err_cnt, pass); end
    ghost_en = 1'b1;                // empty flag stays low after the drain
    run_to_done(1'b0, 1'b1);
    n_cmp++; if (err_cnt !== 3'd1 || pass !== 1'b0) begin n_bad++;
      $display("FAIL flag_empty_missing: err=%0d pass=%b required 1 0", err_cnt, pass); end
    fifo_cap = 2 * DEPTH; corrupt_idx = $urandom_range(0, DEPTH - 1);
    exp_err = sat7(1 + 1 + 1);
    run_to_done(1'b0, 1'b1);
    fifo_cap = DEPTH; ghost_en = 1'b0; corrupt_idx = -1;
    n_cmp++; if (err_cnt !== 3'(exp_err)) begin n_bad++;
      $display("FAIL flag_combined: err=%0d required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_stream();
    int wf0, re0, bw0, w_before, cyc;
    wf0 = wr_while_full; re0 = rd_while_empty; bw0 = bad_wr_data;
    @(negedge clk); mode = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      force_full  = ($urandom_range(0, 3) == 0);
      force_empty = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    force_empty = 1'b0;
    force_full = 1'b1;
    w_before = wr_idx;
    repeat (20) @(negedge clk);
    n_cmp++; if (wr_idx != w_before || busy !== 1'b1) begin n_bad++;
      $display("FAIL stream_full_hold: writes during full=%0d busy=%b required 0 1", wr_idx - w_before, busy); end
    force_full = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stream_timeout: done=%b required 1", done); end
    n_cmp++; if (wr_idx != SLEN || rd_idx != SLEN) begin n_bad++;
      $display("FAIL stream_counts: writes=%0d reads=%0d required %0d", wr_idx, rd_idx, SLEN); end
    n_cmp++; if (wr_while_full != wf0 || rd_while_empty != re0 || bad_wr_data != bw0) begin n_bad++;
      $display("FAIL stream_protocol: wf=%0d re=%0d bad=%0d required 0 0 0",
               wr_while_full - wf0, rd_while_empty - re0, bad_wr_data - bw0); end
    n_cmp++; if (pass !== 1'b1 || err_cnt !== 3'd0) begin n_bad++;
      $display("FAIL stream_result: pass=%b err=%0d required 1 0", pass, err_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    corrupt_idx = 1;                // ensures err_cnt is nonzero when reset hits
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (rd_idx < 20 && cyc < 3000) begin @(negedge clk); cyc++; end
    corrupt_idx = -1;
    n_cmp++; if (rd_idx < 20) begin n_bad++; $display("FAIL mid_drain_timeout: reads=%0d required >=20", rd_idx); end
    tb_rst = 1'b1;
    #1;
    n_cmp++; if ({wr_en, rd_en, busy, done, pass} !== 5'b0 || wr_data !== 16'hFFFF || err_cnt !== 3'd0) begin n_bad++;
      $display("FAIL mid_reset: ctl=%b wr_data=%h err=%0d required 00000 ffff 0",
               {wr_en, rd_en, busy, done, pass}, wr_data, err_cnt); end
    repeat (2) @(negedge clk);
    tb_rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({busy, done, rd_en} !== 3'b0) begin n_bad++;
      $display("FAIL post_reset_idle: busy/done/rd_en=%b required 000", {busy, done, rd_en}); end
    run_to_done(1'b0, 1'b1);
    n_cmp++; if (pass !== 1'b1 || err_cnt !== 3'd0 || wr_idx != DEPTH) begin n_bad++;
      $display("FAIL post_reset_run: pass=%b err=%0d writes=%0d required 1 0 %0d", pass, err_cnt, wr_idx, DEPTH); end
  endtask

`ifdef FIFO_CHK_WATER_LEVEL_EN
  task automatic test_water_level();
    int cyc;
    stuck_level = 1'b1;
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (rd_idx < 1 && cyc < 3000) begin @(negedge clk); cyc++; end
    n_cmp++; if (err_cnt !== 3'd1) begin n_bad++; $display("FAIL level_after_gap: err=%0d required 1", err_cnt); end
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    stuck_level = 1'b0;
    n_cmp++; if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 3'd2) begin n_bad++;
      $display("FAIL level_final: done=%b pass=%b err=%0d required 1 0 2", done, pass, err_cnt); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_corrupt_one();
    test_corrupt_all();
    test_flag_errors();
    test_stream();
    test_reset_mid_drain();
`ifdef FIFO_CHK_WATER_LEVEL_EN
    test_water_level();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_checker.md
FIFO_TRAFFIC_CHECKER -- requirements
Module: fifo_traffic_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 16: FIFO data width in bits, legal range 1..1152.
REQ-002 Parameter DEPTH_WIDTH, default 15: log2 of FIFO depth, legal range 9..20.
REQ-003 Parameter RD_LATENCY, default 1: cycles from rd_en to valid rd_data; legal values 1 (no output register) or 2 (output register).
REQ-004 Parameter STREAM_LEN, default 1024: number of words transferred in streaming mode; legal range 1..2^DEPTH_WIDTH.
REQ-005 Port clk, input, 1 bit: single clock for the checker and both FIFO ports.
REQ-006 Port tb_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 Port start, input, 1 bit: one-cycle pulse that launches a test run.
REQ-008 Port mode, input, 1 bit: sampled on start; 0 = fill-then-drain, 1 = concurrent streaming.
REQ-009 Port wr_en, output, 1 bit: FIFO write enable.
REQ-010 Port wr_data, output, DATA_WIDTH bits: FIFO write data.
REQ-011 Port wr_full, input, 1 bit: FIFO full flag.
REQ-012 Port wr_water_level, input, DEPTH_WIDTH+1 bits: FIFO write-side level; used only when the configuration macro is defined.
REQ-013 Port rd_en, output, 1 bit: FIFO read enable.
REQ-014 Port rd_data, input, DATA_WIDTH bits: FIFO read data.
REQ-015 Port rd_empty, input, 1 bit: FIFO empty flag.
REQ-016 Port busy, output, 1 bit: a run is in progress.
REQ-017 Port done, output, 1 bit: the run has finished; held until the next start or reset.
REQ-018 Port pass, output, 1 bit: done and err_cnt equal to zero.
REQ-019 Port err_cnt, output, 3 bits: saturating mismatch and flag-error count.

Function
REQ-020 FSM states SHALL be IDLE, FILL, GAP, DRAIN, STREAM, FLUSH, DONE.
- Transitions: start from IDLE or DONE goes to FILL (mode=0) or STREAM (mode=1); start is ignored in every other state.
REQ-021 A start SHALL clear err_cnt, done, both word counters, and load the write pattern to all-ones.
REQ-022 Write pattern: wr_data SHALL start at all-ones and decrement by 1 modulo 2^DATA_WIDTH on every cycle with wr_en=1.
REQ-023 FILL behaviour:
- wr_en = !wr_full while fewer than 2^DEPTH_WIDTH writes have been issued.
- Go to GAP in the cycle the 2^DEPTH_WIDTH-th write is issued.
REQ-024 GAP SHALL last exactly 4 cycles with wr_en=rd_en=0.
- In the last GAP cycle, wr_full=0 is a flag error (err_cnt +1).
- Then go to DRAIN.
REQ-025 DRAIN behaviour:
- rd_en = !rd_empty while fewer than 2^DEPTH_WIDTH reads have been issued.
- After the last read is issued, go to FLUSH.
REQ-026 STREAM behaviour:
- wr_en = !wr_full while writes < STREAM_LEN.
- rd_en = !rd_empty AND a free-running toggle bit (50% read throttle) while reads < STREAM_LEN.
- Go to FLUSH when both counts reach STREAM_LEN.
REQ-027 Read check:
- A shift pipeline of depth RD_LATENCY SHALL carry rd_en and an expected-data counter (starting at all-ones, decrementing per issued read).
- When the delayed rd_en=1, rd_data != expected is a data error (err_cnt +1).
REQ-028 FLUSH SHALL last RD_LATENCY+2 cycles.
- In the last FLUSH cycle, rd_empty=0 is a flag error (err_cnt +1).
- Then go to DONE.
REQ-029 err_cnt SHALL saturate at 7; a data error and a flag error in the same cycle SHALL add 2, still saturating at 7.
REQ-030 busy SHALL be 1 in FILL, GAP, DRAIN, STREAM and FLUSH; done SHALL be 1 only in DONE; pass SHALL equal done AND (err_cnt==0).
REQ-031 wr_en and rd_en SHALL never be asserted while wr_full or rd_empty, respectively, is 1 in the same cycle.

Reset
REQ-032 tb_rst SHALL force the following values immediately, including mid-run:
- state = IDLE.
- wr_en = rd_en = 0.
- wr_data = all-ones.
- busy = done = pass = 0.
- err_cnt = 0.
- read pipeline cleared.
REQ-033 After tb_rst deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-034 With macro FIFO_CHK_WATER_LEVEL_EN defined, the checker SHALL also check the water level:
- In the last GAP cycle, wr_water_level != 2^DEPTH_WIDTH is a flag error.
- In the last FLUSH cycle, wr_water_level != 0 is a flag error.
- Without the macro, wr_water_level SHALL be unused and no level checks exist.

Verification
REQ-035 Ideal FIFO model, DEPTH_WIDTH=9, mode=0, start -> 512 writes (0xFFFF down to 0xFE00), 512 reads, done=1, pass=1, err_cnt=0.
REQ-036 Same setup with model data bit 0 inverted on read word 3 -> err_cnt=1, pass=0.
REQ-037 Model with all reads corrupted -> err_cnt saturates at 7 and holds there.
REQ-038 mode=1, STREAM_LEN=100, wr_full forced to 1 for 20 cycles mid-run -> no wr_en while full, 100 words checked, pass=1.
REQ-039 tb_rst pulsed during DRAIN -> all outputs at reset values in the same cycle; a following start completes with pass=1.
REQ-040 FIFO_CHK_WATER_LEVEL_EN defined, model level stuck at 511 -> err_cnt=1 after GAP, pass=0.
